// File: rtl/psram_bist_pkg.sv
// Shared encodings for the psram self-test sequencer: FSM states (exported on o_state),
// pattern modes and the checkerboard words.
package psram_bist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_READY   = 4'd1,
        ST_WR_REQ  = 4'd2,
        ST_WR_ACK  = 4'd3,
        ST_WR_WAIT = 4'd4,
        ST_RD_REQ  = 4'd5,
        ST_RD_ACK  = 4'd6,
        ST_RD_WAIT = 4'd7,
        ST_CHECK   = 4'd8,
        ST_DONE    = 4'd9
    } state_e;

    localparam logic [1:0] MODE_CONST   = 2'd0;
    localparam logic [1:0] MODE_ADDR    = 2'd1;
    localparam logic [1:0] MODE_WALK    = 2'd2;
    localparam logic [1:0] MODE_CHECKER = 2'd3;

    // Wide enough for any practical DATA_W; users slice the low DATA_W bits.
    localparam logic [63:0] CHK_EVEN = {32{2'b10}};
    localparam logic [63:0] CHK_ODD  = {32{2'b01}};

endpackage

// File: rtl/psram_bist_pattern.sv
// Test-pattern generator, shared by the write path and the read-back compare.
module psram_bist_pattern #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16,
    parameter logic [DATA_W-1:0] CONST_PAT = 16'h8765
) (
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  index,
    input  logic [DATA_W-1:0] addr,   // low DATA_W bits of the word address
    output logic [DATA_W-1:0] data
);
    import psram_bist_pkg::*;

    logic [CNT_W-1:0] bit_sel;

    always_comb begin
        bit_sel = index % CNT_W'(DATA_W);
        case (mode)
            MODE_CONST: data = CONST_PAT;
            MODE_ADDR:  data = addr;
            MODE_WALK:  data = DATA_W'(1) << bit_sel;
            default:    data = index[0] ? CHK_ODD[DATA_W-1:0] : CHK_EVEN[DATA_W-1:0];
        endcase
    end

endmodule

// File: rtl/psram_bist.sv
// Psram self-test: writes i_count pattern words, reads them back and reports pass/fail.
// state    | meaning
// IDLE     | out of reset, waiting for i_start
// READY    | test latched, waiting for the controller to be idle
// WR_REQ   | present write request
// WR_ACK   | strobe held until busy rises or the timer expires
// WR_WAIT  | write in flight, waiting for busy to fall
// RD_*     | same handshake for the read-back
// CHECK    | compare the latched read word
// DONE     | results held until the next start
module psram_bist #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16,
    parameter int ERR_W   = 8,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] CONST_PAT = 16'h8765
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_count,
    output logic              o_stb,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_din,
    input  logic              i_busy,
    input  logic [DATA_W-1:0] i_dout,
    output logic              o_running,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout,
    output logic [ERR_W-1:0]  o_err_count,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic [3:0]        o_state
);
    import psram_bist_pkg::*;

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] first_err_q, first_err_d;

    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_pat;
    logic              last_word;

    assign cur_addr  = base_q + ADDR_W'(idx_q);
    assign last_word = (idx_q == count_q - 1'b1);

    psram_bist_pattern #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .CONST_PAT (CONST_PAT)
    ) u_pattern (
        .mode  (mode_q),
        .index (idx_q),
        .addr  (cur_addr[DATA_W-1:0]),
        .data  (cur_pat)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        base_d      = base_q;
        count_d     = count_q;
        idx_d       = idx_q;
        tmr_d       = tmr_q;
        rdata_d     = rdata_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        din_d       = din_q;
        running_d   = running_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        err_d       = err_q;
        first_err_d = first_err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    mode_d      = i_mode;
                    base_d      = i_base_addr;
                    count_d     = i_count;
                    idx_d       = '0;
                    err_d       = '0;
                    timeout_d   = 1'b0;
                    done_d      = 1'b0;
                    first_err_d = '0;
                    running_d   = 1'b1;
                    state_d     = ST_READY;
                end
            end
            ST_READY: begin
                if (count_q == '0) begin
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (!i_busy) begin
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ, ST_RD_REQ: begin
                stb_d   = 1'b1;
                we_d    = (state_q == ST_WR_REQ);
                addr_d  = cur_addr;
                tmr_d   = TMR_W'(TIMEOUT);
                state_d = (state_q == ST_WR_REQ) ? ST_WR_ACK : ST_RD_ACK;
                if (state_q == ST_WR_REQ) begin
                    din_d = cur_pat;
                end
            end
            ST_WR_ACK, ST_RD_ACK: begin
                if (i_busy) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = (state_q == ST_WR_ACK) ? ST_WR_WAIT : ST_RD_WAIT;
                end else if (tmr_q == '0) begin
                    // Controller never accepted the request: abort the whole test.
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    timeout_d = 1'b1;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_WR_WAIT: begin
                if (!i_busy) begin
                    if (last_word) begin
                        idx_d   = '0;
                        state_d = ST_RD_REQ;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_WR_REQ;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (!i_busy) begin
                    rdata_d = i_dout;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (rdata_q != cur_pat) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    // A saturating count never returns to zero, so zero means first miss.
                    if (err_q == '0) begin
                        first_err_d = cur_addr;
                    end
                end
                if (last_word) begin
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_RD_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            base_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            tmr_q       <= '0;
            rdata_q     <= '0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            tmr_q       <= tmr_d;
            rdata_q     <= rdata_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
        end
    end

    assign o_stb            = stb_q;
    assign o_we             = we_q;
    assign o_addr           = addr_q;
    assign o_din            = din_q;
    assign o_running        = running_q;
    assign o_done           = done_q;
    assign o_pass           = done_q && (err_q == '0) && !timeout_q;
    assign o_timeout        = timeout_q;
    assign o_err_count      = err_q;
    assign o_first_err_addr = first_err_q;
    assign o_state          = state_q;

endmodule

// File: tb/tb_psram_bist.sv
// Bench for psram_bist: behavioural psram controller, request scoreboard built from the
// pattern rules, and directed scenarios with literal expectations.
module tb_psram_bist;
    import psram_bist_pkg::*;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_mode = 2'd0;
    logic [23:0] i_base_addr = 24'd0;
    logic [15:0] i_count = 16'd0;
    logic        i_busy;
    logic [15:0] i_dout;
    logic        o_stb, o_we, o_running, o_done, o_pass, o_timeout;
    logic [23:0] o_addr, o_first_err_addr;
    logic [15:0] o_din;
    logic [7:0]  o_err_count;
    logic [3:0]  o_state;

    psram_bist dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
        .i_base_addr(i_base_addr), .i_count(i_count),
        .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_din(o_din),
        .i_busy(i_busy), .i_dout(i_dout),
        .o_running(o_running), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
        .o_err_count(o_err_count), .o_first_err_addr(o_first_err_addr), .o_state(o_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        exp_we   [64];
    logic [23:0] exp_addr [64];
    logic [15:0] exp_din  [64];
    int          exp_n = 0;
    int          exp_ptr = 0;
    int          exp_err = 0;
    logic [23:0] exp_first = 24'd0;
    logic [23:0] got_addr [64];
    logic [15:0] got_din  [64];
    int          stb_rises = 0;
    logic        prev_stb = 1'b0;

    // Controller model: 0 ideal, 1 read data bit 3 stuck at 0, 2 never accepts.
    int          ctrl_kind = 0;
    int          c_phase = 0;
    int          c_cnt = 0;
    logic        c_we;
    logic [23:0] c_addr;
    logic [15:0] c_din;
    logic [15:0] mem [logic [23:0]];

    always @(negedge clk) begin
        if (i_rst) begin
            i_busy  = 1'b0;
            c_phase = 0;
            c_cnt   = 0;
        end else begin
            case (c_phase)
                0: if (o_stb && ctrl_kind != 2) begin
                    c_we = o_we; c_addr = o_addr; c_din = o_din;
                    c_cnt = 1; c_phase = 1;
                end
                1: if (c_cnt == 3) begin
                    i_busy = 1'b1;
                    if (c_we) mem[c_addr] = c_din;
                    else begin
                        i_dout = mem.exists(c_addr) ? mem[c_addr] : 16'hDEAD;
                        if (ctrl_kind == 1) i_dout = i_dout & 16'hFFF7;
                    end
                    c_cnt = 0; c_phase = 2;
                end else c_cnt++;
                default: if (c_cnt == 1) begin
                    i_busy = 1'b0; c_phase = 0;
                end else c_cnt++;
            endcase
        end
    end

    function automatic logic [15:0] pat_m(int mode, int idx, logic [23:0] a);
        case (mode)
            0:       return 16'h8765;
            1:       return a[15:0];
            2:       return 16'(1 << (idx % 16));
            default: return (idx % 2 == 0) ? 16'hAAAA : 16'h5555;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    // Advance one cycle and check any new request against the scoreboard.
    task automatic tick();
        @(negedge clk);
        if (o_stb && !prev_stb) begin
            if (stb_rises < 64) begin
                got_addr[stb_rises] = o_addr;
                got_din[stb_rises]  = o_din;
            end
            stb_rises++;
            if (exp_ptr >= exp_n) fail_now("req_unexpected");
            else begin
                chk("req_we", 32'(o_we), 32'(exp_we[exp_ptr]));
                chk("req_addr", 32'(o_addr), 32'(exp_addr[exp_ptr]));
                if (exp_we[exp_ptr]) chk("req_din", 32'(o_din), 32'(exp_din[exp_ptr]));
                exp_ptr++;
            end
        end
        if (o_stb) chk("stb_while_running", 32'(o_running), 32'd1);
        prev_stb = o_stb;
    endtask

    task automatic build(input int mode, input logic [23:0] base, input int count, input int kind);
        logic [23:0] a;
        logic [15:0] p;
        exp_n = 0; exp_err = 0; exp_first = 24'd0;
        for (int i = 0; i < count; i++) begin
            a = base + 24'(i);
            exp_we[exp_n] = 1'b1; exp_addr[exp_n] = a; exp_din[exp_n] = pat_m(mode, i, a);
            exp_n++;
        end
        for (int i = 0; i < count; i++) begin
            a = base + 24'(i);
            p = pat_m(mode, i, a);
            exp_we[exp_n] = 1'b0; exp_addr[exp_n] = a; exp_din[exp_n] = 16'd0;
            exp_n++;
            if (kind == 1 && (p & 16'h0008) != 16'd0) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        end
        if (exp_err > 255) exp_err = 255;
    endtask

    task automatic start_test(input int mode, input logic [23:0] base, input int count);
        exp_ptr = 0; stb_rises = 0;
        i_mode = 2'(mode); i_base_addr = base; i_count = 16'(count); i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_test(input int mode, input logic [23:0] base, input int count,
                            input int kind, input bit poke);
        int n;
        ctrl_kind = kind;
        build(mode, base, count, kind);
        start_test(mode, base, count);
        n = 0;
        while (!o_done && n < 3000) begin
            tick();
            n++;
            if (poke && n == 30) begin
                i_mode = 2'd0; i_count = 16'd0; i_start = 1'b1;
            end else i_start = 1'b0;
        end
        i_start = 1'b0;
        if (!o_done) fail_now("done_wait");
        else begin
            chk("res_running", 32'(o_running), 32'd0);
            chk("res_pass", 32'(o_pass), 32'(exp_err == 0));
            chk("res_err_count", 32'(o_err_count), 32'(exp_err));
            chk("res_first_err", 32'(o_first_err_addr), 32'(exp_first));
            chk("res_timeout", 32'(o_timeout), 32'd0);
            chk("res_req_total", 32'(exp_ptr), 32'(exp_n));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stb"}, 32'(o_stb), 32'd0);
        chk({tag, "_we"}, 32'(o_we), 32'd0);
        chk({tag, "_addr"}, 32'(o_addr), 32'd0);
        chk({tag, "_din"}, 32'(o_din), 32'd0);
        chk({tag, "_running"}, 32'(o_running), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_pass"}, 32'(o_pass), 32'd0);
        chk({tag, "_timeout"}, 32'(o_timeout), 32'd0);
        chk({tag, "_err"}, 32'(o_err_count), 32'd0);
        chk({tag, "_first"}, 32'(o_first_err_addr), 32'd0);
        chk({tag, "_state"}, 32'(o_state), 32'd0);
    endtask

    initial begin
        int n;
        i_rst = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("por");
        i_rst = 1'b0;
        tick();

        // Constant pattern, single word.
        run_test(0, 24'h000000, 1, 0, 1'b0);
        chk("t1_stb_count", 32'(stb_rises), 32'd2);
        chk("t1_wdata", 32'(got_din[0]), 32'h8765);
        chk("t1_pass", 32'(o_pass), 32'd1);

        // Address pattern across the address wrap; a mid-test start must be ignored.
        run_test(1, 24'hFFFFFE, 4, 0, 1'b1);
        chk("t2_addr0", 32'(got_addr[0]), 32'hFFFFFE);
        chk("t2_addr1", 32'(got_addr[1]), 32'hFFFFFF);
        chk("t2_addr2", 32'(got_addr[2]), 32'h000000);
        chk("t2_addr3", 32'(got_addr[3]), 32'h000001);
        chk("t2_din1", 32'(got_din[1]), 32'hFFFF);
        chk("t2_din3", 32'(got_din[3]), 32'h0001);
        chk("t2_pass", 32'(o_pass), 32'd1);

        // Walking one against a stuck-at-0 data bit 3.
        run_test(2, 24'h000100, 20, 1, 1'b0);
        chk("t3_err_count", 32'(o_err_count), 32'd2);
        chk("t3_first_err", 32'(o_first_err_addr), 32'h000103);
        chk("t3_pass", 32'(o_pass), 32'd0);
        chk("t3_wdata19", 32'(got_din[19]), 32'h0008);

        // Controller never accepts.
        ctrl_kind = 2;
        build(3, 24'h000200, 3, 0);
        exp_n = 1;
        start_test(3, 24'h000200, 3);
        n = 0;
        while (!o_stb && n < 20) begin tick(); n++; end
        if (!o_stb) fail_now("to_stb_rise");
        else begin
            repeat (TIMEOUT) tick();
            chk("to_stb_held", 32'(o_stb), 32'd1);
            chk("to_not_done_yet", 32'(o_done), 32'd0);
            repeat (2) tick();
            chk("to_stb_low", 32'(o_stb), 32'd0);
            chk("to_flag", 32'(o_timeout), 32'd1);
            chk("to_done", 32'(o_done), 32'd1);
            chk("to_pass", 32'(o_pass), 32'd0);
            chk("to_running", 32'(o_running), 32'd0);
        end
        ctrl_kind = 0;

        // Zero-length test.
        build(0, 24'h000000, 0, 0);
        start_test(0, 24'h000000, 0);
        tick();
        chk("c0_done", 32'(o_done), 32'd1);
        chk("c0_pass", 32'(o_pass), 32'd1);
        chk("c0_timeout_cleared", 32'(o_timeout), 32'd0);
        chk("c0_stb_count", 32'(stb_rises), 32'd0);

        // Reset while a read is in flight, then a fresh run.
        build(3, 24'h000040, 4, 0);
        start_test(3, 24'h000040, 4);
        n = 0;
        while (!(exp_ptr >= 5 && !o_stb) && n < 500) begin tick(); n++; end
        if (!(exp_ptr >= 5 && !o_stb)) fail_now("rst_reach_rd_wait");
        chk("rst_in_rd_wait", 32'(o_state), 32'(ST_RD_WAIT));
        i_rst = 1'b1;
        tick();
        chk_reset_outputs("mid_rst");
        tick();
        i_rst = 1'b0;
        exp_n = 0; exp_ptr = 0;
        repeat (5) tick();
        chk("rst_idle_no_stb", 32'(o_stb), 32'd0);
        run_test(3, 24'h000040, 4, 0, 1'b0);
        chk("rst_fresh_pass", 32'(o_pass), 32'd1);
        chk("rst_fresh_wdata1", 32'(got_din[1]), 32'h5555);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
